// File: rtl/if_id_stage_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
// The fetch stage is the master: it raises a request with an address, and memory
// answers with ready and data in the same cycle.
interface if_id_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
// Owns the PC, runs the instruction-memory handshake, and absorbs decode stalls
// with a one-entry hold buffer. EX branch redirects take priority over stalls.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_IF_ID,
  input  logic               branch_taken_EX,
  input  logic [31:0]        branch_target_EX,
  if_id_stage_if.master      imem,
  output logic [31:0]        pc_IF_ID,
  output logic [31:0]        instr_IF_ID,
  output logic               valid_IF_ID,
  output logic [4:0]         rs1_IF_ID,
  output logic [4:0]         rs2_IF_ID,
  output logic [4:0]         rd_IF_ID
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  // Redirect targets are always word aligned; the low two bits are dropped.
  logic [31:0] redirect_pc;
  assign redirect_pc = branch_target_EX & ~32'd3;

  // State register: every flop of the stage, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      pc_q         <= RESET_PC;
      pc_id_q      <= 32'd0;
      instr_id_q   <= NOP_INSTR;
      valid_id_q   <= 1'b0;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_id_q      <= pc_id_d;
      instr_id_q   <= instr_id_d;
      valid_id_q   <= valid_id_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Next-state logic: a stalled handshake parks in HOLD; redirect or stall release leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  state_d = S_FETCH;
      S_FETCH: begin
        if (!branch_taken_EX && imem.imem_ready && stall_IF_ID) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (branch_taken_EX || !stall_IF_ID) state_d = S_FETCH;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Datapath next values: PC, IF/ID register and hold buffer, priority redirect > stall > normal.
  always_comb begin
    pc_d         = pc_q;
    pc_id_d      = pc_id_q;
    instr_id_d   = instr_id_q;
    valid_id_d   = valid_id_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    case (state_q)
      S_WAIT: begin
        if (branch_taken_EX) pc_d = redirect_pc;
      end
      S_FETCH: begin
        if (branch_taken_EX) begin
          // Any data returned this cycle belongs to the wrong path and is dropped.
          pc_d       = redirect_pc;
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
        end else if (imem.imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (!stall_IF_ID) begin
            pc_id_d    = pc_q;
            instr_id_d = imem.imem_rdata;
            valid_id_d = 1'b1;
          end else begin
            // Decode cannot take it yet, so park the fetched word.
            hold_pc_d    = pc_q;
            hold_instr_d = imem.imem_rdata;
          end
        end else if (!stall_IF_ID) begin
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (branch_taken_EX) begin
          hold_pc_d    = 32'd0;
          hold_instr_d = 32'd0;
          instr_id_d   = NOP_INSTR;
          valid_id_d   = 1'b0;
          pc_d         = redirect_pc;
        end else if (!stall_IF_ID) begin
          pc_id_d    = hold_pc_q;
          instr_id_d = hold_instr_q;
          valid_id_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: request only while fetching; address is the PC; decode fields come straight from IF/ID.
  always_comb begin
    imem.imem_req  = (state_q == S_FETCH);
    imem.imem_addr = pc_q;
    pc_IF_ID       = pc_id_q;
    instr_IF_ID    = instr_id_q;
    valid_IF_ID    = valid_id_q;
    rs1_IF_ID      = instr_id_q[19:15];
    rs2_IF_ID      = instr_id_q[24:20];
    rd_IF_ID       = instr_id_q[11:7];
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a behavioural instruction memory, a scoreboard of
// fetched words keyed by the address the bench expects, and directed checks.
module tb_if_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] pc_IF_ID;
  logic [31:0] instr_IF_ID;
  logic        valid_IF_ID;
  logic [4:0]  rs1_IF_ID;
  logic [4:0]  rs2_IF_ID;
  logic [4:0]  rd_IF_ID;

  if_id_stage_if bus ();

  if_id_stage #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_IF_ID      (stall),
    .branch_taken_EX  (br),
    .branch_target_EX (tgt),
    .imem             (bus.master),
    .pc_IF_ID         (pc_IF_ID),
    .instr_IF_ID      (instr_IF_ID),
    .valid_IF_ID      (valid_IF_ID),
    .rs1_IF_ID        (rs1_IF_ID),
    .rs2_IF_ID        (rs2_IF_ID),
    .rd_IF_ID         (rd_IF_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a scrambled function of the address so every word differs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_addr;
  logic        prev_valid;
  logic [31:0] prev_pc;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge: checks the fetch address and IF/ID contents.
  task automatic monitor();
    sb_t e;
    if (bus.imem_req) check("imem_addr", bus.imem_addr, exp_addr);
    if (valid_IF_ID) begin
      if (!prev_valid || pc_IF_ID != prev_pc) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ifid_pc", pc_IF_ID, e.pc);
          check("ifid_instr", instr_IF_ID, e.instr);
          check("ifid_rs1", 32'(rs1_IF_ID), 32'(e.instr[19:15]));
          check("ifid_rs2", 32'(rs2_IF_ID), 32'(e.instr[24:20]));
          check("ifid_rd", 32'(rd_IF_ID), 32'(e.instr[11:7]));
          $display("retire pc=0x%08h instr=0x%08h", pc_IF_ID, instr_IF_ID);
        end
      end
    end else begin
      check("bubble_instr", instr_IF_ID, NOP);
      check("bubble_fields", {17'd0, rs1_IF_ID, rs2_IF_ID, rd_IF_ID}, 32'd0);
      check("bubble_pc_kept", pc_IF_ID, prev_pc);
    end
    prev_valid = valid_IF_ID;
    prev_pc    = pc_IF_ID;
  endtask

  // One clock: drive inputs, record the expected effect, then sample after the next fall.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    bus.imem_ready = r;
    stall          = s;
    br             = b;
    tgt            = t;
    if (b) begin
      sb.delete();
      exp_addr = t & ~32'd3;
    end else if (bus.imem_req && r) begin
      sb.push_back({exp_addr, mem_word(exp_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_addr"}, bus.imem_addr, RST_PC);
    check({tag, "_pc"}, pc_IF_ID, 32'd0);
    check({tag, "_instr"}, instr_IF_ID, NOP);
    check({tag, "_valid"}, 32'(valid_IF_ID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    br = 1'b0;
    tgt = 32'd0;
    bus.imem_ready = 1'b0;
    exp_addr = RST_PC;
    prev_valid = 1'b0;
    prev_pc = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: streaming from RESET_PC with ready high
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t1_req_cycle1", 32'(bus.imem_req), 32'd1);
    check("t1_addr0", bus.imem_addr, 32'h100);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t1_ifid_pc", pc_IF_ID, 32'h100);
    check("t1_ifid_valid", 32'(valid_IF_ID), 32'd1);
    check("t1_addr1", bus.imem_addr, 32'h104);

    // 2: two wait states on 0x104
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("t2_addr_held_a", bus.imem_addr, 32'h104);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("t2_addr_held_b", bus.imem_addr, 32'h104);
    check("t2_valid", 32'(valid_IF_ID), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t2_resume_pc", pc_IF_ID, 32'h104);

    // 3: stall on the handshake of 0x108
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("t3_hold_req", 32'(bus.imem_req), 32'd0);
    check("t3_hold_ifid", pc_IF_ID, 32'h104);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("t3_hold_req2", 32'(bus.imem_req), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t3_release_pc", pc_IF_ID, 32'h108);
    check("t3_release_req", 32'(bus.imem_req), 32'd1);
    check("t3_release_addr", bus.imem_addr, 32'h10C);

    // 4: redirect with a simultaneous handshake
    cycle(1'b1, 1'b0, 1'b1, 32'h203);
    check("t4_addr", bus.imem_addr, 32'h200);
    check("t4_valid", 32'(valid_IF_ID), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t4_ifid_pc", pc_IF_ID, 32'h200);

    // 5: redirect while in HOLD with stall still high
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("t5_in_hold", 32'(bus.imem_req), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h400);
    check("t5_req", 32'(bus.imem_req), 32'd1);
    check("t5_addr", bus.imem_addr, 32'h400);
    check("t5_valid", 32'(valid_IF_ID), 32'd0);

    // Random mix of wait states, stalls and redirects
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 19) == 0),
            32'h1000 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3)));
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // 6: PC wrap, then asynchronous reset in the middle of HOLD
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFA);
    check("t6_addr_f8", bus.imem_addr, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t6_wrap_addr", bus.imem_addr, 32'h0000_0000);
    check("t6_ifid_fc", pc_IF_ID, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    check("t6_hold_req", 32'(bus.imem_req), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    exp_addr = RST_PC;
    prev_valid = 1'b0;
    prev_pc = 32'd0;
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t6_restart_addr", bus.imem_addr, RST_PC);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("t6_restart_pc", pc_IF_ID, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
